// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, VRAM widths and the
// control bundle carried alongside each pixel.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int VRAM_AW = 18;
  localparam int VRAM_DW = 16;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic img;
    logic fs;
  } vga_ctl_t;

  // Idle bundle: syncs deasserted, nothing visible.
  localparam vga_ctl_t CTL_IDLE = '{
    hs: 1'b1, vs: 1'b1, vis: 1'b0, img: 1'b0, fs: 1'b0
  };

  function automatic logic [23:0] rgb565_to_888(
    input logic [15:0] w
  );
    return {w[15:11], w[15:13],
            w[10:5],  w[10:9],
            w[4:0],   w[4:2]};
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// VRAM port-B bundle between the scanout reader
// (master) and the dual-port VRAM (slave).
interface vga_scanout_if;
  import vga_pkg::*;

  logic [VRAM_AW-1:0] vram_addr;
  logic [VRAM_DW-1:0] vram_q;
  logic               vram_we;
  logic [VRAM_DW-1:0] vram_data;

  modport master (
    output vram_addr,
    output vram_we,
    output vram_data,
    input  vram_q
  );

  modport slave (
    input  vram_addr,
    input  vram_we,
    input  vram_data,
    output vram_q
  );

endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider plus 800x525 raster counters and
// the raw sync/visible/frame flags of the current pixel.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       pix_tick_o,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       vis_o,
  output logic       fs_o,
  output logic       frame_end_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] HS_B = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_E = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_B = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_E = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pix_tick_o  = tick;
  assign h_cnt_o     = h_q;
  assign v_cnt_o     = v_q;
  assign hs_o        = !((h_q >= HS_B) && (h_q < HS_E));
  assign vs_o        = !((v_q >= VS_B) && (v_q < VS_E));
  assign vis_o       = (h_q < 10'(H_VIS)) &&
                       (v_q < 10'(V_VIS));
  assign fs_o        = (h_q == '0) && (v_q == '0);
  assign frame_end_o = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout: linear VRAM port-B reader,
// 2-tick pixel pipeline and RGB565 -> RGB888 expansion.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int                 CLK_DIV   = 2,
  parameter int                 IMG_W     = 480,
  parameter int                 IMG_H     = 479,
  parameter logic [VRAM_AW-1:0] BASE_ADDR = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  vga_scanout_if.master vram,
  output logic          hsync,
  output logic          vsync,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          active,
  output logic          frame_start
);

  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       vis_raw;
  logic       fs_raw;
  logic       frame_end;
  logic       in_img;

  vga_timing #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_tick_o  (pix_tick),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .hs_o        (hs_raw),
    .vs_o        (vs_raw),
    .vis_o       (vis_raw),
    .fs_o        (fs_raw),
    .frame_end_o (frame_end)
  );

  assign in_img = (h_cnt < 10'(IMG_W)) &&
                  (v_cnt < 10'(IMG_H));

  vga_ctl_t s0_ctl;
  vga_ctl_t s1_q, s1_d;

  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [VRAM_DW-1:0] word_q, word_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic               fs_q, fs_d;
  logic [23:0]        rgb_q, rgb_d;

  assign s0_ctl = '{
    hs: hs_raw, vs: vs_raw, vis: vis_raw,
    img: in_img, fs: fs_raw
  };

  always_comb begin
    addr_d   = addr_q;
    s1_d     = s1_q;
    word_d   = word_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    rgb_d    = rgb_q;
    fs_d     = 1'b0;
    if (pix_tick) begin
      // Frame wrap wins over the in-image increment.
      if (frame_end) begin
        addr_d = BASE_ADDR;
      end else if (in_img) begin
        addr_d = addr_q + VRAM_AW'(1);
      end
      s1_d     = s0_ctl;
      word_d   = vram.vram_q;
      hsync_d  = s1_q.hs;
      vsync_d  = s1_q.vs;
      active_d = s1_q.vis;
      rgb_d    = (s1_q.img && enable) ?
                 rgb565_to_888(word_q) : '0;
      fs_d     = s1_q.fs;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q   <= BASE_ADDR;
      s1_q     <= CTL_IDLE;
      word_q   <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      rgb_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      s1_q     <= s1_d;
      word_q   <= word_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      rgb_q    <= rgb_d;
      fs_q     <= fs_d;
    end
  end

  assign vram.vram_addr = addr_q;
  assign vram.vram_we   = 1'b0;
  assign vram.vram_data = '0;

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: raster-level model
// predicts every clock; a monitor pops and compares.
module tb_vga_scanout;

  localparam int CD      = 2;
  localparam int BASE    = 100;
  localparam int IW      = 480;
  localparam int IH      = 479;
  localparam int HT      = 800;
  localparam int VT      = 525;
  localparam int FRAME   = HT * VT;
  localparam int MAX_ERR = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       hsync, vsync, active, frame_start;
  logic [7:0] red, green, blue;

  vga_scanout_if vif ();

  vga_scanout #(
    .CLK_DIV   (CD),
    .IMG_W     (IW),
    .IMG_H     (IH),
    .BASE_ADDR (18'(BASE))
  ) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .vram        (vif),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .active      (active),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // VRAM preloaded with mem[a] = a[15:0], 1-clock read.
  always @(posedge clk) vif.vram_q <= vif.vram_addr[15:0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
      if (errors >= MAX_ERR) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic logic [23:0] expand(
    input logic [15:0] w
  );
    int r, g, b;
    r = int'(w[15:11]);
    g = int'(w[10:5]);
    b = int'(w[4:0]);
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16),
            8'(b * 8 + b / 4)};
  endfunction

  // Image pixels that precede raster position p in a frame.
  function automatic int img_before(input int p);
    int h, v, n;
    h = p % HT;
    v = p / HT;
    n = ((v < IH) ? v : IH) * IW;
    if (v < IH) n += (h < IW) ? h : IW;
    return n;
  endfunction

  logic [62:0] sb_q[$];
  int          e = 0;
  logic        en_tick = 1'b1;

  task automatic model_edge();
    int          t, p0, p2, h, v;
    logic        tick, hs, vs, act, fs;
    logic [23:0] rgb;
    logic [17:0] a;
    hs  = 1'b1;
    vs  = 1'b1;
    act = 1'b0;
    fs  = 1'b0;
    rgb = '0;
    if (!reset_n) begin
      e = 0;
      a = 18'(BASE);
    end else begin
      e++;
      t    = e / CD;
      tick = (e % CD) == 0;
      if (tick) en_tick = enable;
      p0 = t % FRAME;
      a  = 18'(BASE + img_before(p0));
      if (t >= 2) begin
        p2  = (t - 2) % FRAME;
        h   = p2 % HT;
        v   = p2 / HT;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= 490 && v < 492);
        act = (h < 640) && (v < 480);
        if (h < IW && v < IH && en_tick)
          rgb = expand(16'(BASE + img_before(p2)));
        fs  = tick && (p2 == 0);
      end
    end
    sb_q.push_back({hs, vs, act, fs, rgb, a, 1'b0, 16'h0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_step();
    if ((e + 1) / CD < 3200) enable = 1'b1;
    else if ($urandom_range(0, 299) == 0) enable = ~enable;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    @(negedge clk);
    repeat (5) step();
    reset_n = 1'b1;
    while (e < 160300 * CD) drive_step();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    while (e < (FRAME + 10) * CD) drive_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [62:0] sb_x;

  always @(posedge clk) begin
    #1;
    while (sb_q.size() > 0) begin
      sb_x = sb_q.pop_front();
      check("pins",
            {1'b0, hsync, vsync, active, frame_start,
             red, green, blue, vif.vram_addr,
             vif.vram_we, vif.vram_data},
            {1'b0, sb_x});
    end
  end

  int   rel = 0;
  int   hs_fall = 0, vs_fall = 0, fs_t = 0;
  logic hs_first = 1'b1, fs_seen = 1'b0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      rel      = 0;
      hs_first = 1'b1;
      fs_seen  = 1'b0;
      hs_prev  = 1'b1;
      vs_prev  = 1'b1;
    end else begin
      rel++;
      if (hs_prev && !hsync) begin
        if (hs_first) check("hs_first_fall", rel, 658 * CD);
        else check("hs_period", rel - hs_fall, HT * CD);
        hs_first = 1'b0;
        hs_fall  = rel;
      end
      if (!hs_prev && hsync)
        check("hs_width", rel - hs_fall, 96 * CD);
      if (vs_prev && !vsync) begin
        if (fs_seen)
          check("vs_offset", rel - fs_t, 490 * HT * CD);
        vs_fall = rel;
      end
      if (!vs_prev && vsync)
        check("vs_width", rel - vs_fall, 2 * HT * CD);
      if (frame_start) begin
        if (fs_seen)
          check("frame_period", rel - fs_t, FRAME * CD);
        else
          check("fs_first", rel, 2 * CD);
        fs_seen = 1'b1;
        fs_t    = rel;
      end
      if (rel == FRAME * CD)
        check("addr_wrap", vif.vram_addr, BASE);
      if (rel == (478 * HT + 479) * CD)
        check("addr_last", vif.vram_addr, BASE + 229919);
      if (rel == (2 * HT + 5 + 2) * CD)
        check("pix_5_2", {red, green, blue},
              expand(16'(BASE + 2 * IW + 5)));
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

endmodule
